store_commit_buf: RTL
=====================

// Module: store_commit_buf
// PURPOSE
//  Responder to the ROB store-commit handshake. Queues address-resolved stores in program order.
//  Writes a store to memory one byte at a time, only after the ROB names it as the committing head.
//  Reports completion to the ROB so the ROB can retire the entry.
//  Sits between EX (store address/data), the ROB commit port and the byte-wide memory controller port.
// PARAMETERS
//  DEPTH   8   queue entries; power of two, >=2
//  NICK_W  5   ROB tag width; tag 0 is never used
//  ADDR_W  32  byte address width
//  DATA_W  32  store data width
// PORTS
//  clk             in   1       clock, rising edge
//  rst             in   1       reset, asynchronous, active-low
//  rdy             in   1       global enable; low freezes all state and forces oMEM_req=0
//  iclr            in   1       misprediction flush, synchronous
//  iST_en          in   1       enqueue one store; upstream guarantees program order
//  iST_nick        in   NICK_W  ROB tag of the store
//  iST_addr        in   ADDR_W  byte address
//  iST_dt          in   DATA_W  store data, LSB-aligned
//  iST_width       in   2       0=SB(1 byte), 1=SH(2), 2=SW(4); 3 treated as SW
//  oST_full        out  1       queue full; combinational from count==DEPTH
//  iROB_store_en   in   1       commit request; level, held by ROB until done
//  iROB_store_nick in   NICK_W  tag of the ROB head store
//  oMEM_req        out  1       byte write request
//  oMEM_addr       out  ADDR_W  byte address = head.addr + idx (mod 2^ADDR_W)
//  oMEM_byte       out  8       head.dt[8*idx +: 8]
//  iMEM_ack        in   1       byte accepted this cycle
//  oROB_done_en    out  1       one-cycle completion pulse (registered)
//  oROB_done_nick  out  NICK_W  tag of the completed store
// BEHAVIOUR
//  Reset: queue empty; rd/wr ptr=0; count=0; state=IDLE; idx=0; orphan=0.
//   Outputs on reset: oMEM_req=0, oMEM_addr=0, oMEM_byte=0, oROB_done_en=0, oROB_done_nick=0.
//  Enqueue: at edge with rdy & iST_en & !oST_full & !iclr.
//   iST_en while full is dropped; there is no same-cycle push-on-pop bypass.
//  FSM IDLE/WRITE/DONE:
//   IDLE->WRITE when rdy & iROB_store_en & count>0 & head.nick==iROB_store_nick.
//    On this transition idx=0 and last=bytes-1.
//    A tag mismatch is ignored and the FSM stays IDLE.
//   WRITE: oMEM_req=1. Each iMEM_ack increments idx.
//    An ack with idx==last moves to DONE.
//    Minimum WRITE cycles = bytes; unbounded if acks stall.
//   DONE: exactly one cycle. Pop head; oROB_done_en=1 (unless orphan), oROB_done_nick=head.nick.
//    DONE->IDLE, orphan cleared. The ROB advances its head on the same edge.
//    The next request is therefore a new tag; a re-asserted stale tag fails the match.
//  oMEM_addr/oMEM_byte: driven from head and idx while in WRITE, otherwise 0.
//  iclr:
//   IDLE: discard all entries (count=0, wr_ptr=rd_ptr).
//   WRITE/DONE: the committed head survives and finishes its bytes; all younger entries are discarded.
//    orphan=1 suppresses its done pulse, because the ROB was flushed.
//   An iclr in the DONE cycle still pops the head, with no pulse.
//  rdy=0: no state change, iMEM_ack ignored, oMEM_req=0, oROB_done_en=0.
//   A DONE pulse that is pending is delayed to the next rdy cycle.
//  Wrap-around: ptrs are log2(DEPTH) bits and wrap naturally.
//   count is log2(DEPTH)+1 bits, range 0..DEPTH.
//  Asynchronous reset mid-WRITE aborts the partial store; no done pulse.
// TESTING
//  T1: enqueue SW nick=3 addr=0x100 dt=0x11223344; commit nick=3; ack every cycle.
//   -> bytes 44,33,22,11 at 0x100..0x103; done nick=3 at cycle 6 after request.
//  T2: SB nick=1 addr=0xFFFFFFFF dt=0xAB.
//   -> single write 0xAB@0xFFFFFFFF.
//   SH nick=2 addr=0xFFFFFFFF dt=0xBEEF -> EF@0xFFFFFFFF, BE@0x0 (wrap).
//  T3: fill 8 entries -> oST_full=1; 9th iST_en dropped; retire one -> full drops; total 8 completions in order.
//  T4: head nick=4, ROB requests nick=5 -> no oMEM_req for 10 cycles; switch to 4 -> write proceeds.
//  T5: 3 queued, iclr mid-WRITE of head -> head bytes complete, no done pulse, count=0 afterwards.
//  T6: rdy low 3 cycles mid-WRITE with ack high -> idx frozen, no bytes lost or duplicated.
//   Also: rst low mid-write -> all outputs 0 immediately.

Source files
------------

// File: rtl/store_commit_buf.sv
// Store commit buffer: queues address-resolved stores in program order and writes the ROB-named
// head store to memory one byte per acknowledged cycle, then reports completion to the ROB.
module store_commit_buf #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned NICK_W = 5,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              iclr,
    input  logic              iST_en,
    input  logic [NICK_W-1:0] iST_nick,
    input  logic [ADDR_W-1:0] iST_addr,
    input  logic [DATA_W-1:0] iST_dt,
    input  logic [1:0]        iST_width,
    output logic              oST_full,
    input  logic              iROB_store_en,
    input  logic [NICK_W-1:0] iROB_store_nick,
    output logic              oMEM_req,
    output logic [ADDR_W-1:0] oMEM_addr,
    output logic [7:0]        oMEM_byte,
    input  logic              iMEM_ack,
    output logic              oROB_done_en,
    output logic [NICK_W-1:0] oROB_done_nick
);

    localparam int unsigned PW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;

    logic [NICK_W-1:0] nick_mem  [DEPTH];
    logic [ADDR_W-1:0] addr_mem  [DEPTH];
    logic [DATA_W-1:0] dt_mem    [DEPTH];
    logic [1:0]        width_mem [DEPTH];

    logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
    logic [PW:0]       count_q;
    state_e            state_q;
    logic [1:0]        idx_q, last_q;
    logic              orphan_q;
    logic              done_en_q;
    logic [NICK_W-1:0] done_nick_q;

    logic [NICK_W-1:0] head_nick;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_dt;
    logic [1:0]        head_width;
    logic [1:0]        head_last;
    logic              push;
    logic              start;

    assign head_nick  = nick_mem[rd_ptr_q];
    assign head_addr  = addr_mem[rd_ptr_q];
    assign head_dt    = dt_mem[rd_ptr_q];
    assign head_width = width_mem[rd_ptr_q];

    // Width code 3 behaves as a word store.
    always_comb begin
        head_last = 2'd3;
        if (head_width == 2'd0) begin
            head_last = 2'd0;
        end else if (head_width == 2'd1) begin
            head_last = 2'd1;
        end
    end

    assign oST_full = (count_q == (PW + 1)'(DEPTH));
    assign push     = rdy & iST_en & ~oST_full & ~iclr;
    assign start    = rdy & iROB_store_en & (count_q != '0) & (head_nick == iROB_store_nick);

    assign oMEM_req       = rdy & (state_q == StWrite);
    assign oMEM_addr      = (state_q == StWrite) ? head_addr + ADDR_W'(idx_q) : '0;
    assign oMEM_byte      = (state_q == StWrite) ? head_dt[{idx_q, 3'b000} +: 8] : 8'h00;
    // A pulse registered while enabled is held back until rdy returns.
    assign oROB_done_en   = done_en_q & rdy;
    assign oROB_done_nick = done_nick_q;

    always_ff @(posedge clk) begin
        if (push) begin
            nick_mem[wr_ptr_q]  <= iST_nick;
            addr_mem[wr_ptr_q]  <= iST_addr;
            dt_mem[wr_ptr_q]    <= iST_dt;
            width_mem[wr_ptr_q] <= iST_width;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= StIdle;
            idx_q       <= 2'd0;
            last_q      <= 2'd0;
            orphan_q    <= 1'b0;
            done_en_q   <= 1'b0;
            done_nick_q <= '0;
        end else if (rdy) begin
            done_en_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (iclr) begin
                        wr_ptr_q <= rd_ptr_q;
                        count_q  <= '0;
                    end else begin
                        if (push) begin
                            wr_ptr_q <= wr_ptr_q + 1'b1;
                            count_q  <= count_q + 1'b1;
                        end
                        if (start) begin
                            state_q <= StWrite;
                            idx_q   <= 2'd0;
                            last_q  <= head_last;
                        end
                    end
                end
                StWrite: begin
                    // The committed head keeps writing; everything younger is dropped.
                    if (iclr) begin
                        orphan_q <= 1'b1;
                        wr_ptr_q <= rd_ptr_q + 1'b1;
                        count_q  <= (PW + 1)'(1);
                    end else if (push) begin
                        wr_ptr_q <= wr_ptr_q + 1'b1;
                        count_q  <= count_q + 1'b1;
                    end
                    if (iMEM_ack) begin
                        idx_q <= idx_q + 1'b1;
                        if (idx_q == last_q) begin
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    state_q     <= StIdle;
                    orphan_q    <= 1'b0;
                    rd_ptr_q    <= rd_ptr_q + 1'b1;
                    done_en_q   <= ~orphan_q & ~iclr;
                    done_nick_q <= head_nick;
                    if (iclr) begin
                        wr_ptr_q <= rd_ptr_q + 1'b1;
                        count_q  <= '0;
                    end else if (push) begin
                        wr_ptr_q <= wr_ptr_q + 1'b1;
                    end else begin
                        count_q <= count_q - 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
